// File: rtl/amp_pwr_seq.sv
// Amplifier power/fault sequencer: keeps the amps in shutdown until the EQ queues
// fill, warms up, then filters amp fault pins with bounded cooldown/retry and lockout.
module amp_pwr_seq #(
  parameter int N_AMP        = 1,
  parameter int STARTUP_CYC  = 250000,
  parameter int FLT_FILT_CYC = 16,
  parameter int COOL_CYC     = 5000000,
  parameter int STABLE_CYC   = 50000000,
  parameter int MAX_RETRY    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_AMP-1:0] Flt_n,
  input  logic             q_full,
  input  logic             clr_lock,
  output logic             sht_dwn,
  output logic             amp_on,
  output logic             locked_out,
  output logic [N_AMP-1:0] flt_src,
  output logic [3:0]       retry_cnt
);

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_WARM = 3'd1,
    ST_RUN  = 3'd2,
    ST_COOL = 3'd3,
    ST_LOCK = 3'd4
  } state_t;

  localparam int FW   = (FLT_FILT_CYC > 1) ? $clog2(FLT_FILT_CYC) : 1;
  localparam int TMAX = (STARTUP_CYC > COOL_CYC) ? STARTUP_CYC : COOL_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  localparam logic [FW-1:0] FLT_TC    = FW'(FLT_FILT_CYC - 1);
  localparam logic [FW-1:0] FLT_ONE   = FW'(1);
  localparam logic [TW-1:0] WARM_TC   = TW'(STARTUP_CYC - 1);
  localparam logic [TW-1:0] COOL_TC   = TW'(COOL_CYC - 1);
  localparam logic [TW-1:0] TM_ONE    = TW'(1);
  localparam logic [SW-1:0] STAB_TC   = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  logic [N_AMP-1:0] sync1_r, sync2_r;
  logic [FW-1:0]    flt_cnt_r;
  logic             flt_hold_r;
  logic             any_low_s, filt_arm_s, flt_det_s;
  state_t           state_r, next_s;
  logic [TW-1:0]    tm_r;
  logic [SW-1:0]    stab_cnt_r;
  logic             sht_dwn_r;
  logic [N_AMP-1:0] flt_src_r;
  logic [3:0]       retry_r;

  // Two-stage synchroniser on the fault pins, preset to the no-fault level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {N_AMP{1'b1}};
      sync2_r <= {N_AMP{1'b1}};
    end else begin
      sync1_r <= Flt_n;
      sync2_r <= sync1_r;
    end
  end

  // Fault filter decode; the filter is only armed while the amps are coming up or running
  always_comb begin
    any_low_s  = ~&sync2_r;
    filt_arm_s = (state_r == ST_WARM) || (state_r == ST_RUN);
    flt_det_s  = any_low_s && filt_arm_s && (flt_cnt_r == FLT_TC) && !flt_hold_r;
  end

  // Shared low-run counter; held clear while disarmed so a persistent fault re-qualifies on each retry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt_r  <= {FW{1'b0}};
      flt_hold_r <= 1'b0;
    end else if (!filt_arm_s || !any_low_s) begin
      flt_cnt_r  <= {FW{1'b0}};
      flt_hold_r <= 1'b0;
    end else begin
      if (flt_cnt_r != FLT_TC) begin
        flt_cnt_r <= flt_cnt_r + FLT_ONE;
      end
      if (flt_det_s) begin
        flt_hold_r <= 1'b1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_OFF: begin
        if (q_full) next_s = ST_WARM;
        else        next_s = ST_OFF;
      end
      ST_WARM: begin
        if (flt_det_s)            next_s = ST_COOL;
        else if (!q_full)         next_s = ST_OFF;
        else if (tm_r == WARM_TC) next_s = ST_RUN;
        else                      next_s = ST_WARM;
      end
      ST_RUN: begin
        if (flt_det_s) next_s = ST_COOL;
        else           next_s = ST_RUN;
      end
      ST_COOL: begin
        if (tm_r == COOL_TC) begin
          if (retry_r == RETRY_MAX) next_s = ST_LOCK;
          else                      next_s = ST_OFF;
        end else begin
          next_s = ST_COOL;
        end
      end
      ST_LOCK: begin
        if (clr_lock) next_s = ST_OFF;
        else          next_s = ST_LOCK;
      end
      default: next_s = ST_OFF;
    endcase
  end

  // State register, state timer and RUN stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_OFF;
      tm_r       <= {TW{1'b0}};
      stab_cnt_r <= {SW{1'b0}};
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        tm_r <= {TW{1'b0}};
      end else if ((state_r == ST_WARM) || (state_r == ST_COOL)) begin
        tm_r <= tm_r + TM_ONE;
      end else begin
        tm_r <= {TW{1'b0}};
      end
      if ((state_r == ST_RUN) && (next_s == ST_RUN)) begin
        if (stab_cnt_r != STAB_TC) stab_cnt_r <= stab_cnt_r + STAB_ONE;
      end else begin
        stab_cnt_r <= {SW{1'b0}};
      end
    end
  end

  // Registered outputs; shutdown drops on RUN entry and rises the cycle after RUN is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sht_dwn_r <= 1'b1;
      flt_src_r <= {N_AMP{1'b0}};
      retry_r   <= 4'd0;
    end else begin
      sht_dwn_r <= !((next_s == ST_RUN) || (state_r == ST_RUN));
      if ((next_s == ST_COOL) && (state_r != ST_COOL)) begin
        flt_src_r <= ~sync2_r;
      end else if ((state_r == ST_LOCK) && clr_lock) begin
        flt_src_r <= {N_AMP{1'b0}};
      end
      if ((state_r == ST_LOCK) && clr_lock) begin
        retry_r <= 4'd0;
      end else if ((state_r == ST_COOL) && (tm_r == COOL_TC) && (retry_r != RETRY_MAX)) begin
        if (retry_r != 4'd15) retry_r <= retry_r + 4'd1;
      end else if ((state_r == ST_RUN) && (stab_cnt_r == STAB_TC)) begin
        retry_r <= 4'd0;
      end
    end
  end

  assign sht_dwn    = sht_dwn_r;
  assign amp_on     = (state_r == ST_RUN);
  assign locked_out = (state_r == ST_LOCK);
  assign flt_src    = flt_src_r;
  assign retry_cnt  = retry_r;

endmodule
